// File: rtl/sample_capture.sv
// sample_capture: synchronizes the PMOD pins, debounces the capture strobe
// and queues one 2-bit sample per debounced rising edge into a small FIFO
// drained by the downstream sequencer.
`timescale 1ns/1ps

module sample_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] pmod,
    output logic [1:0] sample_data,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       run,
    output logic       overflow,
    output logic [4:0] fill_level
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] DEPTH5  = 5'(FIFO_DEPTH);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic          strobe_s;
    logic [7:0]    db_cnt;
    logic          db_strobe;
    logic          db_prev;
    logic          push_req;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [4:0]    count;
    logic          ovf_r;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign strobe_s = sync2[2];
    assign run      = sync2[3];

    // Two-flop synchronizer; the only logic that looks at the raw pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pmod;
            sync2 <= sync1;
        end
    end

    // Debounce: count consecutive cycles the synced strobe disagrees with the
    // accepted level; accept it on the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt    <= '0;
            db_strobe <= 1'b0;
            db_prev   <= 1'b0;
        end else begin
            db_prev <= db_strobe;
            if (strobe_s == db_strobe) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_strobe <= strobe_s;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    // One push request per debounced rising edge; falling edges are ignored.
    assign push_req = db_strobe & ~db_prev;

    // Outputs are gated by run so a flush is visible in the same cycle run drops.
    assign sample_valid = run && (count != 5'd0);
    assign sample_data  = sample_valid ? mem[rptr] : 2'b00;
    assign fill_level   = run ? count : 5'd0;
    assign overflow     = run & ovf_r;

    assign full    = (count == DEPTH5);
    assign do_pop  = sample_valid & sample_ready;
    assign do_push = push_req & run & (~full | do_pop);
    assign drop    = push_req & run & full & ~do_pop;

    // Sample storage, written at the push edge with the synced data pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else if (do_push) begin
            mem[wptr] <= sync2[1:0];
        end
    end

    // Pointers, occupancy and sticky overflow; run low flushes every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_r <= 1'b0;
        end else if (!run) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: directed scenarios plus randomized strobes,
// checked against a queue-based reference model by a negedge monitor.
`timescale 1ns/1ps

module tb_sample_capture;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] data_in = 2'b00;
    logic       strobe_in = 1'b0;
    logic       run_in = 1'b0;
    logic       sample_ready = 1'b0;
    logic [3:0] pmod;
    logic [1:0] sample_data;
    logic       sample_valid;
    logic       run;
    logic       overflow;
    logic [4:0] fill_level;

    assign pmod = {run_in, strobe_in, data_in};

    sample_capture #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pmod         (pmod),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .run          (run),
        .overflow     (overflow),
        .fill_level   (fill_level)
    );

    // 12 MHz board clock
    always #41.667 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_pops = 0;
    int pops_before;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins seen two edges late, a level is accepted once it
    // has persisted DB edges, each accepted rise queues the synced data.
    logic [3:0] m_s1, m_s2;
    logic       m_deb, m_deb_prev, m_last, m_ovf, m_rise;
    int         m_run;
    logic [1:0] sb_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0;
            m_deb = 1'b0; m_deb_prev = 1'b0; m_last = 1'b0; m_ovf = 1'b0;
            m_run = 0;
            sb_q.delete();
        end else begin
            m_rise = m_deb && !m_deb_prev;
            if (!m_s2[3]) begin
                sb_q.delete();
                m_ovf = 1'b0;
            end else if (m_rise) begin
                if (sb_q.size() < DEPTH) sb_q.push_back(m_s2[1:0]);
                else m_ovf = 1'b1;
            end
            m_run = (m_s2[2] == m_last) ? m_run + 1 : 1;
            m_last = m_s2[2];
            m_deb_prev = m_deb;
            if (m_run >= DB && m_s2[2] != m_deb) m_deb = m_s2[2];
            m_s2 = m_s1;
            m_s1 = pmod;
        end
    end

    // Monitor: compares outputs each negedge and pops the scoreboard on a DUT pop.
    int         e_fill;
    logic       e_run;
    logic [1:0] e_data;

    always @(negedge clk) begin
        if (!reset) begin
            e_run  = m_s2[3];
            e_fill = e_run ? sb_q.size() : 0;
            e_data = (e_fill != 0) ? sb_q[0] : 2'b00;
            chk("run", run, e_run);
            chk("fill_level", fill_level, e_fill);
            chk("sample_valid", sample_valid, int'(e_fill != 0));
            chk("sample_data", sample_data, e_data);
            chk("overflow", overflow, int'(e_run && m_ovf));
            if (sample_valid && sample_ready) begin
                n_pops++;
                chk("pop_expected", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) chk("pop_data", sample_data, sb_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_push(input logic [1:0] d);
        data_in = d;
        strobe_in = 1'b1;
        cyc(8);
        strobe_in = 1'b0;
        cyc(7);
    endtask

    task automatic pop_one();
        sample_ready = 1'b1;
        cyc(1);
        sample_ready = 1'b0;
    endtask

    initial begin
        data_in = 2'b11; strobe_in = 1'b1; run_in = 1'b1;
        cyc(3);
        chk("rst_run", run, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_ovf", overflow, 0);

        // first-entry latency with pmod = 1110 applied at release
        #20;
        reset = 1'b0;
        data_in = 2'b10; strobe_in = 1'b1; run_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("lat_e6_valid", sample_valid, 0);
        chk("lat_e6_fill", fill_level, 0);
        @(posedge clk);
        #1;
        chk("lat_e7_valid", sample_valid, 1);
        chk("lat_e7_data", sample_data, 2);
        chk("lat_e7_fill", fill_level, 1);

        // short glitch must not push
        strobe_in = 1'b0;
        cyc(10);
        strobe_in = 1'b1;
        cyc(3);
        strobe_in = 1'b0;
        cyc(10);
        chk("glitch_fill", fill_level, 1);

        run_in = 1'b0; cyc(3); run_in = 1'b1; cyc(3);
        chk("flush_fill", fill_level, 0);

        // five pushes into a four-deep FIFO, then drain
        pops_before = n_pops;
        strobe_push(2'd0); strobe_push(2'd1); strobe_push(2'd2);
        strobe_push(2'd3); strobe_push(2'd0);
        chk("ovfl_fill", fill_level, 4);
        chk("ovfl_flag", overflow, 1);
        sample_ready = 1'b1; cyc(6); sample_ready = 1'b0;
        chk("drain_pops", n_pops - pops_before, 4);
        chk("drain_fill", fill_level, 0);
        chk("ovf_sticky", overflow, 1);
        run_in = 1'b0; cyc(3); run_in = 1'b1; cyc(3);

        // push and pop on the same edge while full
        strobe_push(2'd0); strobe_push(2'd1); strobe_push(2'd2); strobe_push(2'd3);
        chk("full_fill", fill_level, 4);
        chk("full_ovf", overflow, 0);
        data_in = 2'd1; strobe_in = 1'b1;
        cyc(6);
        sample_ready = 1'b1; cyc(1); sample_ready = 1'b0;
        chk("pushpop_fill", fill_level, 4);
        chk("pushpop_ovf", overflow, 0);
        strobe_in = 1'b0; cyc(7);
        strobe_push(2'd2);
        chk("drop_fill", fill_level, 4);
        chk("drop_ovf", overflow, 1);
        pop_one();
        chk("three_fill", fill_level, 3);

        // run low clears everything two edges later
        run_in = 1'b0;
        cyc(1);
        chk("run_e1", run, 1);
        cyc(1);
        chk("run_e2", run, 0);
        chk("run_e2_fill", fill_level, 0);
        chk("run_e2_valid", sample_valid, 0);
        chk("run_e2_ovf", overflow, 0);
        run_in = 1'b1; cyc(3);

        // asynchronous reset between edges with data queued, strobe held high
        strobe_push(2'd3); strobe_push(2'd1);
        chk("pre_rst_fill", fill_level, 2);
        data_in = 2'd0; strobe_in = 1'b1;
        cyc(2);
        #20;
        reset = 1'b1;
        #2;
        chk("arst_valid", sample_valid, 0);
        chk("arst_data", sample_data, 0);
        chk("arst_fill", fill_level, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_run", run, 0);
        #10;
        reset = 1'b0;
        cyc(1);

        fork
            begin
                repeat (100) begin
                    data_in = 2'($urandom);
                    cyc(4);
                end
            end
            begin
                repeat (60) begin
                    strobe_in = ~strobe_in;
                    cyc($urandom_range(5, 7));
                end
            end
            begin
                repeat (400) begin
                    sample_ready = ($urandom_range(0, 3) == 0);
                    cyc(1);
                end
            end
        join
        sample_ready = 1'b1;
        cyc(20);
        sample_ready = 1'b0;
        chk("end_fill", fill_level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
